// File: rtl/btn_repeat_ctrl.sv
// btn_repeat_ctrl: per-channel button debouncer with press pulse and auto-repeat
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   btn        raw asynchronous active-high buttons, one bit per channel
//   repeat_en  per-channel auto-repeat enable
//   out_btn    registered one-cycle action pulses (press plus repeats)
//   btn_level  registered debounced button level
module btn_repeat_ctrl #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] out_btn,
    output logic [N_BTN-1:0] btn_level
);
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int W      = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [W-1:0] DEB_LAST  = W'(DEBOUNCE_CYCLES - 1);
    localparam logic [W-1:0] DLY_LAST  = W'(REPEAT_DELAY - 1);
    localparam logic [W-1:0] RATE_LAST = W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [N_BTN-1:0] sync1, sync2, level_n, pulse_n;
    logic [W-1:0]     dcnt [N_BTN];
    logic [W-1:0]     dcnt_n [N_BTN];
    logic [W-1:0]     tmr [N_BTN];
    logic [W-1:0]     tmr_n [N_BTN];
    state_t           state [N_BTN];
    state_t           state_n [N_BTN];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_level <= '0;
            out_btn   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt[i]  <= '0;
                tmr[i]   <= '0;
                state[i] <= IDLE;
            end
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            btn_level <= level_n;
            out_btn   <= pulse_n;
            dcnt      <= dcnt_n;
            tmr       <= tmr_n;
            state     <= state_n;
        end
    end

    // The FSM reacts to the next debounced level so the press pulse and the
    // release land on the same edge as the btn_level change.
    always_comb begin
        level_n = btn_level;
        pulse_n = '0;
        dcnt_n  = dcnt;
        tmr_n   = tmr;
        state_n = state;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2[i] == btn_level[i]) begin
                dcnt_n[i] = '0;
            end else if (dcnt[i] == DEB_LAST) begin
                level_n[i] = sync2[i];
                dcnt_n[i]  = '0;
            end else begin
                dcnt_n[i] = dcnt[i] + W'(1);
            end
            case (state[i])
                IDLE: begin
                    if (level_n[i] && !btn_level[i]) begin
                        pulse_n[i] = 1'b1;
                        state_n[i] = DELAY;
                        tmr_n[i]   = '0;
                    end
                end
                DELAY, REPEAT: begin
                    // release outranks a coinciding timer expiry
                    if (!level_n[i]) begin
                        state_n[i] = IDLE;
                        tmr_n[i]   = '0;
                    end else if (!repeat_en[i]) begin
                        state_n[i] = DELAY;
                        tmr_n[i]   = '0;
                    end else if (tmr[i] == ((state[i] == DELAY) ? DLY_LAST : RATE_LAST)) begin
                        pulse_n[i] = 1'b1;
                        state_n[i] = REPEAT;
                        tmr_n[i]   = '0;
                    end else begin
                        tmr_n[i] = tmr[i] + W'(1);
                    end
                end
                default: begin
                    state_n[i] = IDLE;
                    tmr_n[i]   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// tb_btn_repeat_ctrl: checks btn_repeat_ctrl against a timing model and literal expectations
module tb_btn_repeat_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = '0;
    logic [3:0] repeat_en = '0;
    logic [3:0] out_btn, btn_level;

    btn_repeat_ctrl #(
        .N_BTN(4), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .repeat_en(repeat_en),
        .out_btn(out_btn), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // Model: level flips after DEB consecutive edges of disagreement with the
    // two-edge-delayed input; while held, pulses fall at RD after the anchor
    // and then every RR, the anchor being the press or the last disabled edge.
    logic [3:0] m_s1 = '0, m_s2 = '0, exp_lvl = '0, exp_out = '0;
    int mis [4];
    int anchor [4];
    int t = 0;

    always @(posedge clk) begin : model
        int  d;
        logic old;
        t++;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            exp_lvl = '0;
            exp_out = '0;
            for (int c = 0; c < 4; c++) mis[c] = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                old = exp_lvl[c];
                mis[c] = (m_s2[c] != exp_lvl[c]) ? mis[c] + 1 : 0;
                if (mis[c] == DEB) begin
                    exp_lvl[c] = m_s2[c];
                    mis[c] = 0;
                end
                exp_out[c] = 1'b0;
                if (exp_lvl[c] && !old) begin
                    exp_out[c] = 1'b1;
                    anchor[c] = t;
                end else if (exp_lvl[c] && old) begin
                    if (!repeat_en[c]) begin
                        anchor[c] = t;
                    end else begin
                        d = t - anchor[c];
                        exp_out[c] = (d == RD) || (d > RD && (d - RD) % RR == 0);
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    int total = 0;
    int bad = 0;
    logic [3:0] seen_out, seen_lvl;
    int pcnt [4];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0d: got %b want %b", name, t, got, want);
        end
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            chk("model out_btn", out_btn, exp_out);
            chk("model btn_level", btn_level, exp_lvl);
            seen_out |= out_btn;
            seen_lvl |= btn_level;
            for (int c = 0; c < 4; c++) if (out_btn[c]) pcnt[c]++;
        end
    endtask

    task automatic clr_seen();
        seen_out = '0;
        seen_lvl = '0;
        for (int c = 0; c < 4; c++) pcnt[c] = 0;
    endtask

    initial begin
        clr_seen();
        step(3);
        chk("reset out_btn", out_btn, 4'b0000);
        chk("reset btn_level", btn_level, 4'b0000);
        rst = 1'b0;
        step(2);

        // single press with repeats, then release on a repeat edge
        repeat_en = 4'b0001;
        btn = 4'b0001;
        step(5);
        chk("press not yet level", btn_level, 4'b0000);
        step(1);
        chk("press pulse k+5", out_btn, 4'b0001);
        chk("press level k+5", btn_level, 4'b0001);
        step(9);
        chk("quiet k+14", out_btn, 4'b0000);
        step(1);
        chk("first repeat k+15", out_btn, 4'b0001);
        step(3);
        chk("repeat k+18", out_btn, 4'b0001);
        step(3);
        chk("repeat k+21", out_btn, 4'b0001);
        btn = 4'b0000;
        step(5);
        chk("held before fall", btn_level, 4'b0001);
        step(1);
        chk("release beats repeat out", out_btn, 4'b0000);
        chk("release level", btn_level, 4'b0000);
        step(3);
        btn = 4'b0001;
        step(6);
        chk("re-press pulse", out_btn, 4'b0001);
        btn = 4'b0000;
        step(10);

        // 3-cycle glitch on channel 1
        clr_seen();
        btn = 4'b0010;
        step(3);
        btn = 4'b0000;
        step(10);
        chk("glitch out seen", seen_out, 4'b0000);
        chk("glitch level seen", seen_lvl, 4'b0000);

        // channel 2 held 40 cycles without repeat
        clr_seen();
        repeat_en = 4'b0000;
        btn = 4'b0100;
        step(40);
        btn = 4'b0000;
        step(5);
        chk("no-repeat level held", btn_level, 4'b0100);
        step(1);
        chk("no-repeat level fall", btn_level, 4'b0000);
        chk("no-repeat pulse count", 4'(pcnt[2]), 4'd1);
        step(5);

        // reset in the middle of a repeat train on channel 3
        repeat_en = 4'b1111;
        btn = 4'b1000;
        step(20);
        rst = 1'b1;
        step(1);
        chk("rst out_btn", out_btn, 4'b0000);
        chk("rst btn_level", btn_level, 4'b0000);
        step(1);
        rst = 1'b0;
        step(5);
        chk("post-rst no early pulse", out_btn, 4'b0000);
        step(1);
        chk("post-rst press pulse", out_btn, 4'b1000);
        step(10);
        chk("post-rst first repeat", out_btn, 4'b1000);
        btn = 4'b0000;
        step(10);

        // all four together, then a repeat_en toggle on channel 0
        btn = 4'b1111;
        step(6);
        chk("all press", out_btn, 4'b1111);
        step(10);
        chk("all first repeat", out_btn, 4'b1111);
        step(3);
        chk("all second repeat", out_btn, 4'b1111);
        repeat_en = 4'b1110;
        step(2);
        repeat_en = 4'b1111;
        step(9);
        chk("restarted delay quiet", out_btn[0] ? 4'b0001 : 4'b0000, 4'b0000);
        step(1);
        chk("restarted delay pulse", {3'b000, out_btn[0]}, 4'b0001);
        btn = 4'b0000;
        step(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
